clk_enable_bank: RTL and testbench

Parametrised clock-enable generator that derives `NUM_CH` independent divided-rate strobes and phase levels from a single fabric clock. Replaces fixed DCM-style ratios (core = bus/2) with runtime-programmable, glitch-free ratio changes, a start-up lock delay and per-channel synchronous reset release. It sits between the board clock buffer and the core/bus/peripheral domains. Those domains run on `clk_i` and gate their logic with `en_o[k]`.

---
 rtl/clk_gen_pkg.sv | 16 +
 rtl/clk_div_channel.sv | 49 ++++
 rtl/clk_enable_bank.sv | 55 +++++
 tb/tb_clk_enable_bank.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/clk_gen_pkg.sv
// clk_gen_pkg: shared widths and helpers for the clock-enable bank
// Provides the default ratio width, the lock counter width for the default
// lock delay, a lock-width helper and a ratio-field extractor.
package clk_gen_pkg;
  localparam int DIV_W_DEF = 8;
  localparam int LOCK_CYCLES_DEF = 16;
  localparam int LOCK_W = $clog2(LOCK_CYCLES_DEF + 1);
  localparam int BUS_MAX = 256;
  localparam int SLICE_MAX = 32;
  function automatic int lock_w(input int n);
    return $clog2(n + 1);
  endfunction
  function automatic logic [SLICE_MAX-1:0] div_slice(input logic [BUS_MAX-1:0] bus, input int k, input int w);
    return SLICE_MAX'(bus >> (k * w)) & ((SLICE_MAX'(1) << w) - SLICE_MAX'(1));
  endfunction
endpackage

// File: rtl/clk_div_channel.sv
// clk_div_channel: one programmable divide-by-(N+1) enable/phase channel
// Ports: clk_i/rst_n_i clock and async active-low reset; locked_i lock state
// this cycle; run_i lock state after this edge; resync_i realign (pre-gated);
// load_i/div_i pending ratio load; en_o period-start strobe; phase_o divided
// level; rst_n_o synchronously released channel reset.
module clk_div_channel
  import clk_gen_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 1
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             locked_i,
  input  logic             run_i,
  input  logic             resync_i,
  input  logic             load_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             en_o,
  output logic             phase_o,
  output logic             rst_n_o
);
  logic [DIV_W-1:0] pend, act, cnt, new_div, nxt_act, nxt_cnt;
  logic wrap;
  // A load in the wrap cycle bypasses pending so it governs the next period.
  always_comb begin
    new_div = load_i ? div_i : pend;
    wrap = locked_i & (resync_i | (cnt == act));
    nxt_act = wrap ? new_div : act;
    nxt_cnt = (!locked_i || wrap) ? '0 : cnt + 1'b1;
  end
  // en/phase are decoded from the next count so they are clean flop outputs.
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      pend <= DIV_W'(DEFAULT_DIV);
      act <= DIV_W'(DEFAULT_DIV);
      cnt <= '0;
      en_o <= 1'b0;
      phase_o <= 1'b0;
      rst_n_o <= 1'b0;
    end else begin
      pend <= new_div;
      act <= nxt_act;
      cnt <= nxt_cnt;
      en_o <= run_i & (nxt_cnt == '0);
      phase_o <= run_i & (nxt_cnt <= (nxt_act >> 1));
      rst_n_o <= rst_n_o | (locked_i & en_o);
    end
endmodule

// File: rtl/clk_enable_bank.sv
// clk_enable_bank: lock-delayed bank of programmable clock-enable channels
// Ports: clk_i/rst_n_i clock and async active-low reset; div_i/div_load_i
// per-channel ratio fields and load strobes; resync_i realigns all channels;
// en_o/phase_o per-channel strobes and levels; locked_o lock delay elapsed;
// rst_n_o per-channel synchronously released resets.
module clk_enable_bank
  import clk_gen_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int DIV_W = DIV_W_DEF,
  parameter int DEFAULT_DIV = 1,
  parameter int LOCK_CYCLES = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [NUM_CH*DIV_W-1:0] div_i,
  input  logic [NUM_CH-1:0]       div_load_i,
  input  logic                    resync_i,
  output logic [NUM_CH-1:0]       en_o,
  output logic [NUM_CH-1:0]       phase_o,
  output logic                    locked_o,
  output logic [NUM_CH-1:0]       rst_n_o
);
  localparam int LCW = lock_w(LOCK_CYCLES);
  localparam logic [LCW-1:0] LOCK_MAX = LCW'(LOCK_CYCLES);
  logic [LCW-1:0] lcnt;
  logic [BUS_MAX-1:0] div_bus;
  logic run, rs;
  // run is the lock state after this edge, letting channels start on the lock edge.
  assign run = locked_o | (lcnt == LOCK_MAX);
  assign rs = resync_i & locked_o;
  assign div_bus = BUS_MAX'(div_i);
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      lcnt <= '0;
      locked_o <= 1'b0;
    end else begin
      lcnt <= lcnt + LCW'(lcnt != LOCK_MAX);
      locked_o <= run;
    end
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    clk_div_channel #(.DIV_W(DIV_W), .DEFAULT_DIV(DEFAULT_DIV)) u_ch (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .locked_i (locked_o),
      .run_i    (run),
      .resync_i (rs),
      .load_i   (div_load_i[i]),
      .div_i    (DIV_W'(div_slice(div_bus, i, DIV_W))),
      .en_o     (en_o[i]),
      .phase_o  (phase_o[i]),
      .rst_n_o  (rst_n_o[i])
    );
  end
endmodule

// File: tb/tb_clk_enable_bank.sv
// tb_clk_enable_bank: randomized and directed check of clk_enable_bank against a period model
module tb_clk_enable_bank;
  localparam int NC = 2;
  localparam int DW = 8;
  localparam int DD = 1;
  localparam int LC = 16;
  logic clk_i = 1'b0;
  logic rst_n_i = 1'b0;
  logic resync_i = 1'b0;
  logic [NC*DW-1:0] div_i = '0;
  logic [NC-1:0] div_load_i = '0;
  logic [NC-1:0] en_o, phase_o, rst_n_o;
  logic locked_o;
  int errs = 0, checks = 0;
  int mt, edges;
  bit m_lock;
  int start[NC], len[NC], pend[NC], rel_t[NC];
  always #5 clk_i = ~clk_i;
  clk_enable_bank #(.NUM_CH(NC), .DIV_W(DW), .DEFAULT_DIV(DD), .LOCK_CYCLES(LC)) dut (
    .clk_i      (clk_i),
    .rst_n_i    (rst_n_i),
    .div_i      (div_i),
    .div_load_i (div_load_i),
    .resync_i   (resync_i),
    .en_o       (en_o),
    .phase_o    (phase_o),
    .locked_o   (locked_o),
    .rst_n_o    (rst_n_o)
  );
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic int slice(input int k);
    return int'(div_i[k*DW +: DW]);
  endfunction
  task automatic model_reset();
    mt = -1;
    edges = 0;
    m_lock = 0;
    for (int k = 0; k < NC; k++) begin
      start[k] = 0;
      len[k] = DD + 1;
      pend[k] = DD;
      rel_t[k] = -1;
    end
  endtask
  function automatic bit x_en(input int k);
    return m_lock && (mt == start[k]);
  endfunction
  function automatic bit x_ph(input int k);
    return m_lock && ((mt - start[k]) < (len[k] + 1) / 2);
  endfunction
  function automatic bit x_rst(input int k);
    return (rel_t[k] >= 0) && (mt > rel_t[k]);
  endfunction
  // Model: each channel is a period start time plus a period length.
  task automatic model_edge();
    bit was;
    int nd;
    was = m_lock;
    mt++;
    m_lock = was || (edges == LC);
    edges++;
    for (int k = 0; k < NC; k++) begin
      nd = div_load_i[k] ? slice(k) : pend[k];
      if (!was) begin
        if (m_lock) start[k] = mt;
      end else if (resync_i || (mt - start[k] == len[k])) begin
        start[k] = mt;
        len[k] = nd + 1;
      end
      if (div_load_i[k]) pend[k] = slice(k);
      if (x_en(k) && rel_t[k] < 0) rel_t[k] = mt;
    end
  endtask
  task automatic compare();
    for (int k = 0; k < NC; k++) begin
      chk($sformatf("en%0d t%0d", k, mt), en_o[k], x_en(k));
      chk($sformatf("phase%0d t%0d", k, mt), phase_o[k], x_ph(k));
      chk($sformatf("rst_n%0d t%0d", k, mt), rst_n_o[k], x_rst(k));
    end
    chk($sformatf("locked t%0d", mt), locked_o, m_lock);
  endtask
  task automatic step();
    @(posedge clk_i);
    model_edge();
    @(negedge clk_i);
    compare();
  endtask
  task automatic load(input int k, input int v);
    div_i[k*DW +: DW] = DW'(v);
    div_load_i[k] = 1'b1;
  endtask
  task automatic measure(input int k, output int per, output int hi);
    int n;
    n = 0;
    per = 0;
    hi = 0;
    while (!en_o[k] && n < 64) begin
      step();
      n++;
    end
    chk($sformatf("en%0d wait", k), n < 64, 1);
    do begin
      if (phase_o[k]) hi++;
      per++;
      step();
    end while (!en_o[k] && per < 64);
  endtask
  task automatic lock_seq();
    for (int i = 0; i < LC; i++) begin
      resync_i = (i == 4);
      step();
      if (i == LC - 1) chk("locked before", locked_o, 0);
    end
    resync_i = 1'b0;
    step();
    chk("locked at 16", locked_o, 1);
    chk("en at 16", en_o, 2'b11);
    chk("phase at 16", phase_o, 2'b11);
    chk("rst_n at 16", rst_n_o, 2'b00);
    step();
    chk("rst_n at 17", rst_n_o, 2'b11);
    chk("en at 17", en_o, 2'b00);
    step();
    chk("en at 18", en_o, 2'b11);
  endtask
  initial begin
    int per, hi, n, r;
    model_reset();
    #1;
    chk("reset outs", {en_o, phase_o, rst_n_o, locked_o}, 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    lock_seq();
    // ratio 3 on channel 1 loaded at cnt=0
    n = 0;
    while (!en_o[1] && n < 8) begin step(); n++; end
    load(1, 3);
    step();
    div_load_i = '0;
    chk("ch1 old period kept", en_o[1], 0);
    measure(1, per, hi);
    chk("ch1 period 4", per, 4);
    chk("ch1 high 2", hi, 2);
    measure(0, per, hi);
    chk("ch0 period 2", per, 2);
    // ratio 2 on channel 0
    load(0, 2);
    step();
    div_load_i = '0;
    step();
    step();
    measure(0, per, hi);
    chk("ch0 period 3", per, 3);
    chk("ch0 high 2", hi, 2);
    // load in the wrap cycle takes effect at once
    n = 0;
    while ((mt - start[0] != len[0] - 1) && n < 16) begin step(); n++; end
    chk("wrap wait", n < 16, 1);
    load(0, 1);
    step();
    div_load_i = '0;
    chk("wrap load en", en_o[0], 1);
    measure(0, per, hi);
    chk("wrap load period 2", per, 2);
    // divide by 1
    load(0, 0);
    step();
    div_load_i = '0;
    for (int i = 0; i < 4; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("div1 en/phase", {en_o[0], phase_o[0]}, 2'b11);
      step();
    end
    // resync with simultaneous load
    load(0, 4);
    load(1, 6);
    step();
    div_load_i = '0;
    for (int i = 0; i < 15; i++) step();
    resync_i = 1'b1;
    load(1, 1);
    step();
    resync_i = 1'b0;
    div_load_i = '0;
    chk("resync en", en_o, 2'b11);
    measure(1, per, hi);
    chk("resync ch1 period 2", per, 2);
    measure(0, per, hi);
    chk("ch0 period 5", per, 5);
    chk("ch0 high 3", hi, 3);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 99);
      for (int k = 0; k < NC; k++) div_i[k*DW +: DW] = DW'($urandom_range(0, 5));
      div_load_i = (r < 20) ? NC'($urandom) : '0;
      resync_i = (r >= 97);
      step();
    end
    div_load_i = '0;
    resync_i = 1'b0;
    // asynchronous reset mid-period
    #2;
    rst_n_i = 1'b0;
    #1;
    chk("async clear", {en_o, phase_o, rst_n_o, locked_o}, 0);
    model_reset();
    @(negedge clk_i);
    @(negedge clk_i);
    rst_n_i = 1'b1;
    lock_seq();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
